// File: rtl/spike_arb_pkg.sv
// Shared types for the spike SRAM arbiter: the owner tag that names
// who drives the SRAM port in a cycle, and the pushback buffer entry.
package spike_arb_pkg;

  // Field widths of a pushback entry. These match the default core of
  // 256 one-byte spike entries.
  localparam int SPIKE_ADDR_W = 8;
  localparam int SPIKE_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_OBI,
    OWN_FILT,
    OWN_PB
  } owner_e;

  typedef struct packed {
    logic [SPIKE_ADDR_W-1:0] addr;
    logic [SPIKE_DATA_W-1:0] data;
  } pb_entry_t;

  // Byte-lane write strobe for a byte address within a 32-bit word.
  function automatic logic [3:0] byte_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/spike_pb_fifo.sv
// Small synchronous FIFO that holds AER pushback entries until the
// arbiter finds a free SRAM cycle. Full/empty derive only from the
// registered count, so the ready signal has no path from a pop.
module spike_pb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at a power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_sram_arbiter.sv
// Arbiter for the single-port spike SRAM word port shared by the OBI
// bus slave, the spike filter scan and the AER pushback path. Grants
// are combinational, responses arrive exactly one cycle later, and
// pushback writes are buffered so none is lost on a collision.
module spike_sram_arbiter
  import spike_arb_pkg::*;
#(
  parameter int N            = 256,
  parameter int INPUT_RESO   = 8,
  parameter int PB_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    obi_req_i,
  input  logic                    obi_we_i,
  input  logic [3:0]              obi_be_i,
  input  logic [$clog2(N)-3:0]    obi_addr_i,
  input  logic [31:0]             obi_wdata_i,
  output logic                    obi_gnt_o,
  output logic                    obi_rvalid_o,
  output logic [31:0]             obi_rdata_o,
  input  logic                    filt_req_i,
  input  logic [$clog2(N)-3:0]    filt_addr_i,
  output logic                    filt_gnt_o,
  output logic                    filt_rvalid_o,
  output logic [31:0]             filt_rdata_o,
  input  logic                    pb_valid_i,
  input  logic [$clog2(N)-1:0]    pb_addr_i,
  input  logic [INPUT_RESO-1:0]   pb_data_i,
  output logic                    pb_ready_o,
  output logic                    sram_en_o,
  output logic [3:0]              sram_we_o,
  output logic [$clog2(N)-3:0]    sram_addr_o,
  output logic [31:0]             sram_wdata_o,
  input  logic [31:0]             sram_rdata_i,
  output logic                    busy_o
);

  localparam int BW = $clog2(N);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam int CW = $clog2(PB_DEPTH+1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  owner_e          owner;
  owner_e          owner_q;
  logic [SW-1:0]   starve_cnt;
  pb_entry_t       in_entry;
  pb_entry_t       head_entry;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            push;
  logic            pop;

  assign in_entry.addr = pb_addr_i;
  assign in_entry.data = pb_data_i;
  assign pb_ready_o    = !fifo_full;
  assign push          = pb_valid_i && pb_ready_o;
  assign pop           = (owner == OWN_PB);

  spike_pb_fifo #(
    .DEPTH (PB_DEPTH),
    .WIDTH ($bits(pb_entry_t))
  ) u_pb_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .wdata (in_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Pick this cycle's owner; a full buffer wins so pushback never stalls
  // forever, and a starved filter beats the bus. Nothing is granted while
  // reset is held so buffered entries are dropped rather than written.
  always_comb begin
    owner = OWN_NONE;
    if (RST) begin
      owner = OWN_NONE;
    end else if (fifo_full) begin
      owner = OWN_PB;
    end else if (filt_req_i && (starve_cnt == STARVE_MAX)) begin
      owner = OWN_FILT;
    end else if (obi_req_i) begin
      owner = OWN_OBI;
    end else if (filt_req_i) begin
      owner = OWN_FILT;
    end else if (!fifo_empty) begin
      owner = OWN_PB;
    end
  end

  // Drive the SRAM port from whichever requester owns it this cycle.
  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    case (owner)
      OWN_OBI: begin
        sram_en_o    = 1'b1;
        sram_we_o    = obi_we_i ? obi_be_i : 4'b0000;
        sram_addr_o  = obi_addr_i;
        sram_wdata_o = obi_wdata_i;
      end
      OWN_FILT: begin
        sram_en_o    = 1'b1;
        sram_addr_o  = filt_addr_i;
      end
      OWN_PB: begin
        sram_en_o    = 1'b1;
        sram_we_o    = byte_onehot(head_entry.addr[1:0]);
        sram_addr_o  = head_entry.addr[BW-1:2];
        sram_wdata_o = {4{head_entry.data}};
      end
      default: begin
        sram_en_o    = 1'b0;
      end
    endcase
  end

  // Remember who owned the port so the response goes back to them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner;
    end
  end

  // Count consecutive cycles the filter asked and lost, saturating.
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (!filt_req_i || (owner == OWN_FILT)) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign obi_gnt_o     = (owner == OWN_OBI);
  assign filt_gnt_o    = (owner == OWN_FILT);
  assign obi_rvalid_o  = (owner_q == OWN_OBI);
  assign filt_rvalid_o = (owner_q == OWN_FILT);
  assign obi_rdata_o   = obi_rvalid_o ? sram_rdata_i : 32'h0;
  assign filt_rdata_o  = filt_rvalid_o ? sram_rdata_i : 32'h0;
  assign busy_o        = (fifo_count != '0) || obi_rvalid_o || filt_rvalid_o;

endmodule

// File: tb/tb_spike_sram_arbiter.sv
// Bench for spike_sram_arbiter. Directed sequences push the SRAM
// accesses and read responses they expect into queues; a monitor pops
// and compares whenever the DUT enables the SRAM or raises an rvalid.
module tb_spike_sram_arbiter;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          obi_req, obi_we;
  logic [3:0]    obi_be;
  logic [AW-1:0] obi_addr;
  logic [31:0]   obi_wdata;
  logic          obi_gnt, obi_rvalid;
  logic [31:0]   obi_rdata;
  logic          filt_req;
  logic [AW-1:0] filt_addr;
  logic          filt_gnt, filt_rvalid;
  logic [31:0]   filt_rdata;
  logic          pb_valid;
  logic [7:0]    pb_addr, pb_data;
  logic          pb_ready;
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = 32'h0;
  logic          busy;

  logic [31:0]   mem [64];
  logic [41:0]   exp_sram [$];
  logic [31:0]   exp_obi [$];
  logic [31:0]   exp_filt [$];
  int            checks = 0;
  int            errors = 0;
  logic [6:0]    t5_obi, t5_push, t5_gnt, t5_rdy;

  spike_sram_arbiter dut (
    .CLK           (clk),
    .RST           (rst),
    .obi_req_i     (obi_req),
    .obi_we_i      (obi_we),
    .obi_be_i      (obi_be),
    .obi_addr_i    (obi_addr),
    .obi_wdata_i   (obi_wdata),
    .obi_gnt_o     (obi_gnt),
    .obi_rvalid_o  (obi_rvalid),
    .obi_rdata_o   (obi_rdata),
    .filt_req_i    (filt_req),
    .filt_addr_i   (filt_addr),
    .filt_gnt_o    (filt_gnt),
    .filt_rvalid_o (filt_rvalid),
    .filt_rdata_o  (filt_rdata),
    .pb_valid_i    (pb_valid),
    .pb_addr_i     (pb_addr),
    .pb_data_i     (pb_data),
    .pb_ready_o    (pb_ready),
    .sram_en_o     (sram_en),
    .sram_we_o     (sram_we),
    .sram_addr_o   (sram_addr),
    .sram_wdata_o  (sram_wdata),
    .sram_rdata_i  (sram_rdata),
    .busy_o        (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Byte-writable SRAM that returns the old word one cycle after access.
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= mem[sram_addr];
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic o_req, input logic o_we, input logic [3:0] o_be,
                               input logic [AW-1:0] o_addr, input logic [31:0] o_wdata,
                               input logic f_req, input logic [AW-1:0] f_addr,
                               input logic p_valid, input logic [7:0] p_addr, input logic [7:0] p_data);
    @(posedge clk);
    #1;
    obi_req = o_req; obi_we = o_we; obi_be = o_be; obi_addr = o_addr; obi_wdata = o_wdata;
    filt_req = f_req; filt_addr = f_addr;
    pb_valid = p_valid; pb_addr = p_addr; pb_data = p_data;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 4'h0, '0, 32'h0, 0, '0, 0, 8'h0, 8'h0);
  endtask

  task automatic expectSram(input logic [3:0] we, input logic [AW-1:0] addr, input logic [31:0] wd);
    exp_sram.push_back({we, addr, wd});
  endtask

  task automatic obiRead(input logic [AW-1:0] addr, input logic [31:0] data);
    applyStimulus(1, 0, 4'h0, addr, 32'h0, 0, '0, 0, 8'h0, 8'h0);
    expectSram(4'h0, addr, 32'h0);
    exp_obi.push_back(data);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_obi_gnt", obi_gnt, 0);
    checkOutput("rst_obi_rvalid", obi_rvalid, 0);
    checkOutput("rst_obi_rdata", obi_rdata, 0);
    checkOutput("rst_filt_gnt", filt_gnt, 0);
    checkOutput("rst_filt_rvalid", filt_rvalid, 0);
    checkOutput("rst_filt_rdata", filt_rdata, 0);
    checkOutput("rst_sram_en", sram_en, 0);
    checkOutput("rst_sram_we", sram_we, 0);
    checkOutput("rst_sram_addr", sram_addr, 0);
    checkOutput("rst_sram_wdata", sram_wdata, 0);
    checkOutput("rst_pb_ready", pb_ready, 1);
    checkOutput("rst_busy", busy, 0);
  endtask

  // Monitor: every SRAM access and every response must match the next
  // queued expectation; idle outputs must be zero.
  always @(negedge clk) begin
    if (sram_en) begin
      if (exp_sram.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL sram_unexpected got=%h exp=none", {sram_we, sram_addr, sram_wdata});
      end else begin
        checkOutput("sram_access", {sram_we, sram_addr, sram_wdata}, exp_sram.pop_front());
      end
    end else begin
      checkOutput("sram_idle", {sram_we, sram_addr, sram_wdata}, 0);
    end
    if (obi_rvalid) begin
      if (exp_obi.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL obi_rvalid_unexpected got=%h exp=none", obi_rdata);
      end else begin
        checkOutput("obi_rdata", obi_rdata, exp_obi.pop_front());
      end
    end else begin
      checkOutput("obi_rdata_idle", obi_rdata, 0);
    end
    if (filt_rvalid) begin
      if (exp_filt.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL filt_rvalid_unexpected got=%h exp=none", filt_rdata);
      end else begin
        checkOutput("filt_rdata", filt_rdata, exp_filt.pop_front());
      end
    end else begin
      checkOutput("filt_rdata_idle", filt_rdata, 0);
    end
  end

  // Directed sequences.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
    rst = 1'b1;
    obi_req = 0; obi_we = 0; obi_be = '0; obi_addr = '0; obi_wdata = '0;
    filt_req = 0; filt_addr = '0; pb_valid = 0; pb_addr = '0; pb_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetValues();

    // OBI write then read of word 3
    applyStimulus(1, 1, 4'b0101, 6'd3, 32'hAABBCCDD, 0, '0, 0, 8'h0, 8'h0);
    expectSram(4'b0101, 6'd3, 32'hAABBCCDD);
    exp_obi.push_back(32'hC0DE0003);
    @(negedge clk);
    checkOutput("wr_gnt", obi_gnt, 1);
    checkOutput("wr_rvalid_early", obi_rvalid, 0);
    obiRead(6'd3, 32'hC0BB00DD);
    @(negedge clk);
    checkOutput("rd_gnt", obi_gnt, 1);
    checkOutput("wr_rvalid", obi_rvalid, 1);
    applyIdle();
    @(negedge clk);
    checkOutput("rd_rvalid", obi_rvalid, 1);
    checkOutput("idle_gnt", obi_gnt, 0);

    // Single pushback with bus and filter idle
    applyStimulus(0, 0, 4'h0, '0, 32'h0, 0, '0, 1, 8'h0E, 8'h05);
    expectSram(4'b0100, 6'd3, 32'h05050505);
    @(negedge clk);
    checkOutput("pb1_ready", pb_ready, 1);
    checkOutput("pb1_busy_push", busy, 0);
    applyIdle();
    @(negedge clk);
    checkOutput("pb1_busy_held", busy, 1);
    applyIdle();
    @(negedge clk);
    checkOutput("pb1_busy_fall", busy, 0);

    // Five pushbacks against a continuously requesting bus
    for (int k = 0; k < 4; k++) expectSram(4'h0, 6'd10, 32'h0);
    expectSram(4'b0001, 6'd8, 32'h11111111);
    expectSram(4'h0, 6'd10, 32'h0);
    expectSram(4'b0010, 6'd8, 32'h12121212);
    expectSram(4'b0100, 6'd8, 32'h13131313);
    expectSram(4'b1000, 6'd8, 32'h14141414);
    expectSram(4'b0001, 6'd9, 32'h15151515);
    for (int k = 0; k < 5; k++) exp_obi.push_back(32'hC0DE000A);
    for (int c = 0; c < 11; c++) begin
      int e;
      e = (c < 4) ? c : 4;
      if (c <= 5) applyStimulus(1, 0, 4'h0, 6'd10, 32'h0, 0, '0, 1, 8'(8'h20 + e), 8'(8'h11 + e));
      else applyIdle();
      @(negedge clk);
      if (c <= 5) begin
        checkOutput("fill_ready", pb_ready, (c != 4));
        checkOutput("fill_obi_gnt", obi_gnt, (c != 4));
      end
      if (c == 6) checkOutput("fill_full_again", pb_ready, 0);
      if (c == 10) checkOutput("fill_busy_end", busy, 0);
    end
    obiRead(6'd8, 32'h14131211);
    obiRead(6'd9, 32'hC0DE0015);
    applyIdle();

    // Filter starved by the bus until the limit
    for (int k = 0; k < 8; k++) expectSram(4'h0, 6'd21, 32'h0);
    expectSram(4'h0, 6'd20, 32'h0);
    expectSram(4'h0, 6'd21, 32'h0);
    for (int k = 0; k < 9; k++) exp_obi.push_back(32'hC0DE0015);
    exp_filt.push_back(32'hC0DE0014);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 4'h0, 6'd21, 32'h0, (i <= 8), 6'd20, 0, 8'h0, 8'h0);
      @(negedge clk);
      checkOutput("starve_obi_gnt", obi_gnt, (i != 8));
      checkOutput("starve_filt_gnt", filt_gnt, (i == 8));
      if (i == 9) checkOutput("starve_filt_rvalid", filt_rvalid, 1);
    end
    applyIdle();

    // Simultaneous push and pop at count 2, crossing the pointer wrap
    t5_obi  = 7'b1111011;
    t5_push = 7'b0011111;
    t5_gnt  = 7'b1011011;
    t5_rdy  = 7'b1011111;
    expectSram(4'h0, 6'd30, 32'h0);
    expectSram(4'h0, 6'd30, 32'h0);
    expectSram(4'b0001, 6'd12, 32'h21212121);
    expectSram(4'h0, 6'd30, 32'h0);
    expectSram(4'h0, 6'd30, 32'h0);
    expectSram(4'b0010, 6'd12, 32'h22222222);
    expectSram(4'h0, 6'd30, 32'h0);
    expectSram(4'b0100, 6'd12, 32'h23232323);
    expectSram(4'b1000, 6'd12, 32'h24242424);
    expectSram(4'b0001, 6'd13, 32'h25252525);
    for (int k = 0; k < 5; k++) exp_obi.push_back(32'hC0DE001E);
    for (int c = 0; c < 11; c++) begin
      if (c <= 6) applyStimulus(t5_obi[c], 0, 4'h0, 6'd30, 32'h0, 0, '0,
                                t5_push[c], 8'(8'h30 + c), 8'(8'h21 + c));
      else applyIdle();
      @(negedge clk);
      if (c <= 6) begin
        checkOutput("wrap_ready", pb_ready, t5_rdy[c]);
        checkOutput("wrap_obi_gnt", obi_gnt, t5_gnt[c]);
      end
      if (c == 10) checkOutput("wrap_busy_end", busy, 0);
    end
    obiRead(6'd12, 32'h24232221);
    obiRead(6'd13, 32'hC0DE0025);
    applyIdle();

    // Reset with three buffered entries and a response pending
    for (int k = 0; k < 3; k++) begin
      expectSram(4'h0, 6'd40, 32'h0);
      exp_obi.push_back(32'hC0DE0028);
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 0, 4'h0, 6'd40, 32'h0, 0, '0, 1, 8'(8'h40 + c), 8'(8'h31 + c));
      @(negedge clk);
      checkOutput("rstq_obi_gnt", obi_gnt, 1);
    end
    applyIdle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstq_pending_rvalid", obi_rvalid, 1);
    applyIdle();
    rst = 1'b0;
    @(negedge clk);
    checkResetValues();
    repeat (6) applyIdle();
    obiRead(6'd16, 32'hC0DE0010);
    applyIdle();

    // Every queued expectation must have been consumed
    for (int i = 0; i < 20 && (exp_sram.size() + exp_obi.size() + exp_filt.size()) != 0; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("drain_sram", exp_sram.size(), 0);
    checkOutput("drain_obi", exp_obi.size(), 0);
    checkOutput("drain_filt", exp_filt.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
